fibonacci_index_finder: RTL and testbench

//  Inverse of the Fibonacci calculator: given a WIDTH-bit value, iteratively finds the

---
 rtl/fibo_pkg.sv | 7 +
 rtl/fibo_zeck_walker.sv | 25 ++
 rtl/fibonacci_index_finder.sv | 113 +++++++++++
 tb/tb_fibonacci_index_finder.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fibo_pkg.sv
// fibo_pkg: shared defaults and FSM encoding for the Fibonacci index finder
package fibo_pkg;
  localparam int FIBO_WIDTH = 16;
  localparam int FIBO_IDX_W = 5;
  localparam int FIBO_MAX_IDX = 24;
  typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_ZECK, ST_DONE} fibo_state_t;
endpackage

// File: rtl/fibo_zeck_walker.sv
// fibo_zeck_walker: one Zeckendorf step, F(i-1)=F(i+1)-F(i) plus greedy subtract of F(i)
module fibo_zeck_walker
  import fibo_pkg::*;
#(
  parameter int WIDTH = FIBO_WIDTH,
  parameter int IDX_W = FIBO_IDX_W,
  parameter int MAX_IDX = FIBO_MAX_IDX
) (
  input  logic [WIDTH:0]     fi,
  input  logic [WIDTH:0]     fi_next,
  input  logic [WIDTH:0]     r,
  input  logic [IDX_W-1:0]   i,
  input  logic [MAX_IDX-2:0] mask,
  output logic [WIDTH:0]     fi_prev,
  output logic [WIDTH:0]     r_next,
  output logic [MAX_IDX-2:0] mask_next
);
  logic take;
  always_comb begin
    take = fi <= r && i >= IDX_W'(2);
    fi_prev = fi_next - fi;
    r_next = take ? r - fi : r;
    mask_next = mask | (take ? (MAX_IDX-1)'(1) << (i - IDX_W'(2)) : '0);
  end
endmodule

// File: rtl/fibonacci_index_finder.sv
// fibonacci_index_finder: iterative F->n decoder (largest n with F(n) <= value).
// Define FIBO_ZECK_EN to add the Zeckendorf walk and the zeck_mask port.
module fibonacci_index_finder
  import fibo_pkg::*;
#(
  parameter int WIDTH = FIBO_WIDTH,
  parameter int IDX_W = FIBO_IDX_W,
  parameter int MAX_IDX = FIBO_MAX_IDX
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   value_in,
  input  logic               begin_inv,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   fibo_index,
  output logic [WIDTH-1:0]   fibo_floor,
`ifdef FIBO_ZECK_EN
  output logic [MAX_IDX-2:0] zeck_mask,
`endif
  output logic               is_fibo
);
  fibo_state_t state;
  logic [WIDTH:0] a, b, v;
  logic [IDX_W-1:0] k;
`ifdef FIBO_ZECK_EN
  logic [MAX_IDX-2:0] zm, mask_next;
  logic [WIDTH:0] fi_prev, r_next;
  // a/b/v/k are reused as F(i)/F(i+1)/remainder/i while walking back down
  fibo_zeck_walker #(.WIDTH(WIDTH), .IDX_W(IDX_W), .MAX_IDX(MAX_IDX)) u_walk (
    .fi(a), .fi_next(b), .r(v), .i(k), .mask(zm),
    .fi_prev(fi_prev), .r_next(r_next), .mask_next(mask_next)
  );
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= ST_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      fibo_index <= '0;
      fibo_floor <= '0;
      is_fibo <= 1'b0;
      a <= '0;
      b <= (WIDTH+1)'(1);
      k <= '0;
      v <= '0;
`ifdef FIBO_ZECK_EN
      zm <= '0;
      zeck_mask <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE:
          if (begin_inv) begin
            v <= {1'b0, value_in};
            a <= '0;
            b <= (WIDTH+1)'(1);
            k <= '0;
            done <= 1'b0;
            busy <= 1'b1;
            state <= ST_SEARCH;
`ifdef FIBO_ZECK_EN
            zm <= '0;
`endif
          end
        ST_SEARCH:
          if (b <= v) begin
            a <= b;
            b <= a + b;
            k <= k + IDX_W'(1);
          end else begin
            fibo_index <= k;
            fibo_floor <= a[WIDTH-1:0];
            is_fibo <= a == v;
`ifdef FIBO_ZECK_EN
            if (k > IDX_W'(2)) begin
              a <= fi_prev;
              b <= a;
              k <= k - IDX_W'(1);
              v <= r_next;
              zm <= mask_next;
              state <= ST_ZECK;
            end else begin
              zeck_mask <= mask_next;
              busy <= 1'b0;
              done <= 1'b1;
              state <= ST_DONE;
            end
`else
            busy <= 1'b0;
            done <= 1'b1;
            state <= ST_DONE;
`endif
          end
`ifdef FIBO_ZECK_EN
        ST_ZECK: begin
          a <= fi_prev;
          b <= a;
          k <= k - IDX_W'(1);
          v <= r_next;
          zm <= mask_next;
          if (k == IDX_W'(2)) begin
            zeck_mask <= mask_next;
            busy <= 1'b0;
            done <= 1'b1;
            state <= ST_DONE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_fibonacci_index_finder.sv
// tb_fibonacci_index_finder: random and directed decode runs against an array-based Fibonacci model
module tb_fibonacci_index_finder;
  logic clk = 0, reset_n = 0, begin_inv = 0;
  logic [15:0] value_in = '0;
  logic busy, done, is_fibo;
  logic [4:0] fibo_index;
  logic [15:0] fibo_floor;
`ifdef FIBO_ZECK_EN
  logic [22:0] zeck_mask;
`endif
  int checks = 0, errors = 0;

  fibonacci_index_finder dut (
    .clk(clk), .reset_n(reset_n), .value_in(value_in), .begin_inv(begin_inv),
    .busy(busy), .done(done), .fibo_index(fibo_index), .fibo_floor(fibo_floor),
`ifdef FIBO_ZECK_EN
    .zeck_mask(zeck_mask),
`endif
    .is_fibo(is_fibo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model(input int v, output int n, output int fl, output bit isf,
                                output int mask, output int lat);
    int f[0:25];
    int r;
    f[0] = 0;
    f[1] = 1;
    for (int i = 2; i <= 25; i++) f[i] = f[i-1] + f[i-2];
    n = 0;
    for (int i = 0; i <= 24; i++) if (f[i] <= v) n = i;
    fl = f[n];
    isf = fl == v;
    r = v;
    mask = 0;
    for (int i = 24; i >= 2; i--)
      if (f[i] <= r) begin
        mask |= 1 << (i - 2);
        r -= f[i];
      end
    lat = n + 2;
`ifdef FIBO_ZECK_EN
    if (n > 2) lat += n - 2;
`endif
  endfunction

  // edges counts the sampling edge as 1; returns the edge count at which done was seen
  task automatic run(input logic [15:0] val, input bit interfere, output int edges);
    value_in = val;
    begin_inv = 1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    begin_inv = 0;
    value_in = 16'($urandom);
    check("busy_after_start", busy, 1);
    if (interfere) begin
      begin_inv = 1;
      @(posedge clk);
      edges++;
      @(negedge clk);
      begin_inv = 0;
    end
    while (!done && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic run_check(input logic [15:0] val, input bit interfere);
    int n, fl, mask, lat, edges;
    bit isf;
    model(val, n, fl, isf, mask, lat);
    run(val, interfere, edges);
    check($sformatf("latency[%0d]", val), edges, lat);
    check($sformatf("index[%0d]", val), fibo_index, n);
    check($sformatf("floor[%0d]", val), fibo_floor, fl);
    check($sformatf("is_fibo[%0d]", val), is_fibo, isf);
    check($sformatf("busy_done[%0d]", val), busy, 0);
`ifdef FIBO_ZECK_EN
    check($sformatf("zeck[%0d]", val), zeck_mask, mask);
`endif
  endtask

  initial begin
    int done_cnt, run_len, max_run, waited;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_index", fibo_index, 0);
    check("rst_floor", fibo_floor, 0);
    check("rst_is_fibo", is_fibo, 0);
`ifdef FIBO_ZECK_EN
    check("rst_zeck", zeck_mask, 0);
`endif
    reset_n = 1;
    @(negedge clk);
    run_check(16'd0, 0);
    run_check(16'd1, 0);
    run_check(16'd100, 0);
    run_check(16'd65535, 0);
    run_check(16'd46368, 0);
    run_check(16'd2, 0);
    run_check(16'd4, 0);
    run_check(16'd50000, 1);
    run_check(16'd30000, 1);
    for (int i = 0; i < 25; i++) run_check(16'($urandom_range(0, 65535)), 0);
    for (int i = 0; i < 5; i++) run_check(16'($urandom_range(0, 200)), 0);

    // begin_inv held high: each run must pulse done for exactly one cycle
    done_cnt = 0;
    run_len = 0;
    max_run = 0;
    value_in = 16'd3;
    begin_inv = 1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      run_len = done ? run_len + 1 : 0;
      if (done) done_cnt++;
      if (run_len > max_run) max_run = run_len;
    end
    begin_inv = 0;
    check("held_done_width", max_run, 1);
    check("held_restarts", done_cnt >= 3, 1);
    waited = 0;
    while (!done && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    check("held_settle", done, 1);

    // async reset mid-search clears every output immediately
    value_in = 16'd65535;
    begin_inv = 1;
    @(posedge clk);
    @(negedge clk);
    begin_inv = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset_n = 0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_index", fibo_index, 0);
    check("mid_rst_floor", fibo_floor, 0);
    check("mid_rst_is_fibo", is_fibo, 0);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    run_check(16'd46368, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
